// File: rtl/ras_link_stack.sv
// ras_link_stack: return-address stack stored as linked nodes in an internal BRAM, client of a free-address allocator
// Ports: clk, rst_n (async active-low); push/push_data, pop (call/return requests); ready (request accepted);
//   pop_data (top-of-stack, zero-latency); empty, full, count (occupancy);
//   alloc, alloc_addr, de_alloc, last_alloc_addr, alloc_reset, alloc_reset_addr (allocator handshake);
//   err (sticky illegal-request flag, present only when RAS_LINK_STACK_ERR_EN is defined).
module ras_link_stack #(
  parameter int ADDR  = 4,
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic [ADDR:0]    count,
  output logic             alloc,
  output logic             de_alloc,
  output logic [ADDR-1:0]  last_alloc_addr,
  output logic             alloc_reset,
  output logic [ADDR-1:0]  alloc_reset_addr,
`ifdef RAS_LINK_STACK_ERR_EN
  output logic             err,
`endif
  input  logic [ADDR-1:0]  alloc_addr
);
  typedef enum logic [1:0] {INIT, IDLE, REFILL} state_t;
  state_t state, state_n;
  logic [WIDTH+ADDR-1:0] mem [DEPTH];
  logic [WIDTH+ADDR-1:0] rd_q, wr_data;
  logic [ADDR-1:0] top_ptr, top_next, wr_addr;
  logic [WIDTH-1:0] top_data;
  logic swap, wr_en;
  assign pop_data = top_data;
  assign empty = count == '0;
  assign full = count == (ADDR+1)'(DEPTH);
  assign last_alloc_addr = top_ptr;
  assign alloc_reset_addr = '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= INIT;
    else state <= state_n;
  // INIT and REFILL each last a single cycle; only a pop that leaves entries behind needs a refill
  always_comb begin
    state_n = IDLE;
    ready = state == IDLE;
    // gated by rst_n so the pulse shows only in the first cycle after release, not while held in reset
    alloc_reset = state == INIT && rst_n;
    swap = ready && push && pop && !empty;
    alloc = ready && push && !full && !swap;
    de_alloc = ready && pop && !push && !empty;
    if (de_alloc && count != (ADDR+1)'(1)) state_n = REFILL;
  end
  // a swap rewrites the top node in place, keeping its link to the entry below
  assign wr_en = alloc || swap;
  assign wr_addr = swap ? top_ptr : alloc_addr;
  assign wr_data = {push_data, swap ? top_next : top_ptr};
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_q <= (wr_en && wr_addr == top_next) ? wr_data : mem[top_next];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      top_ptr <= '0;
      top_next <= '0;
      top_data <= '0;
      count <= '0;
    end else if (alloc) begin
      top_next <= top_ptr;
      top_ptr <= alloc_addr;
      top_data <= push_data;
      count <= count + 1'b1;
    end else if (de_alloc) begin
      top_ptr <= top_next;
      count <= count - 1'b1;
    end else if (swap) begin
      top_data <= push_data;
    end else if (state == REFILL) begin
      top_data <= rd_q[WIDTH+ADDR-1:ADDR];
      top_next <= rd_q[ADDR-1:0];
    end
`ifdef RAS_LINK_STACK_ERR_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else if (ready && ((push && !pop && full) || (pop && !push && empty))) err <= 1'b1;
`endif
endmodule

// File: tb/tb_ras_link_stack.sv
// tb_ras_link_stack: directed self-checking bench for ras_link_stack
module tb_ras_link_stack;
  logic clk = 0, rst_n = 0, push = 0, pop = 0;
  logic [31:0] push_data = 0;
  logic [3:0] alloc_addr = 0;
  logic ready, empty, full, alloc, de_alloc, alloc_reset;
  logic [31:0] pop_data;
  logic [4:0] count;
  logic [3:0] last_alloc_addr, alloc_reset_addr;
`ifdef RAS_LINK_STACK_ERR_EN
  logic err;
`endif
  int tests = 0, fails = 0, n_alloc = 0;
  logic s_alloc, s_de;
  logic [3:0] s_last;
  logic [31:0] s_pop;
  ras_link_stack dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_data(push_data), .pop(pop),
    .ready(ready), .pop_data(pop_data), .empty(empty), .full(full), .count(count),
    .alloc(alloc), .de_alloc(de_alloc), .last_alloc_addr(last_alloc_addr),
    .alloc_reset(alloc_reset), .alloc_reset_addr(alloc_reset_addr),
`ifdef RAS_LINK_STACK_ERR_EN
    .err(err),
`endif
    .alloc_addr(alloc_addr)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic pu, input logic po, input logic [31:0] d, input logic [3:0] a);
    push = pu; pop = po; push_data = d; alloc_addr = a;
    #1;
    s_alloc = alloc; s_de = de_alloc; s_last = last_alloc_addr; s_pop = pop_data;
    if (alloc) n_alloc++;
    @(posedge clk); #1;
    push = 0; pop = 0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_ready", ready, 0);
    check("rst_alloc_reset", alloc_reset, 0);
    check("rst_pop_data", pop_data, 0);
    rst_n = 1; #1;
    check("init_pulse", alloc_reset, 1);
    check("init_ready", ready, 0);
    check("init_addr", alloc_reset_addr, 0);
    @(posedge clk); #1;
    check("init_pulse_end", alloc_reset, 0);
    check("idle_ready", ready, 1);
    check("idle_empty", empty, 1);
    step(1, 0, 32'hA0, 0);
    check("push0_alloc", s_alloc, 1);
    step(1, 0, 32'hB0, 1);
    step(1, 0, 32'hC0, 2);
    check("push3_count", count, 3);
    check("push3_top", pop_data, 32'hC0);
    check("push3_allocs", n_alloc, 3);
    step(0, 1, 0, 0);
    check("pop1_data", s_pop, 32'hC0);
    check("pop1_de", s_de, 1);
    check("pop1_addr", s_last, 2);
    check("pop1_busy", ready, 0);
    step(0, 0, 0, 0);
    check("pop1_ready", ready, 1);
    step(0, 1, 0, 0);
    check("pop2_data", s_pop, 32'hB0);
    check("pop2_addr", s_last, 1);
    check("pop2_busy", ready, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    check("pop3_data", s_pop, 32'hA0);
    check("pop3_addr", s_last, 0);
    check("pop3_ready", ready, 1);
    check("pop3_empty", empty, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 32'h100 + i, 4'(i));
    check("fill_count", count, 16);
    check("fill_full", full, 1);
    check("fill_top", pop_data, 32'h10F);
    step(1, 0, 32'hFF, 0);
    check("ovf_alloc", s_alloc, 0);
    check("ovf_count", count, 16);
    check("ovf_top", pop_data, 32'h10F);
    check("ovf_full", full, 1);
`ifdef RAS_LINK_STACK_ERR_EN
    check("ovf_err", err, 1);
`endif
    step(0, 1, 0, 0);
    check("refill_busy", ready, 0);
    rst_n = 0; #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_ready", ready, 0);
    @(posedge clk); #1;
    rst_n = 1; #1;
    check("mid_init_pulse", alloc_reset, 1);
    @(posedge clk); #1;
    check("mid_init_end", alloc_reset, 0);
    check("mid_ready", ready, 1);
`ifdef RAS_LINK_STACK_ERR_EN
    check("err_cleared", err, 0);
`endif
    step(1, 0, 32'h08, 3);
    step(1, 0, 32'h10, 5);
    check("swap_pre_count", count, 2);
    check("swap_pre_top", pop_data, 32'h10);
    step(1, 1, 32'h20, 7);
    check("swap_old", s_pop, 32'h10);
    check("swap_no_alloc", s_alloc, 0);
    check("swap_no_de", s_de, 0);
    check("swap_new", pop_data, 32'h20);
    check("swap_count", count, 2);
    step(0, 1, 0, 0);
    check("swap_pop_data", s_pop, 32'h20);
    check("swap_pop_addr", s_last, 5);
    step(0, 0, 0, 0);
    check("swap_below", pop_data, 32'h08);
    step(0, 1, 0, 0);
    check("last_pop_addr", s_last, 3);
    check("last_empty", empty, 1);
    step(0, 1, 0, 0);
    check("udf_de", s_de, 0);
    check("udf_count", count, 0);
`ifdef RAS_LINK_STACK_ERR_EN
    check("udf_err", err, 1);
`endif
    step(1, 1, 32'h55, 9);
    check("pp_empty_alloc", s_alloc, 1);
    check("pp_empty_de", s_de, 0);
    check("pp_empty_count", count, 1);
    check("pp_empty_top", pop_data, 32'h55);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
